// File: rtl/img_mem_pkg.sv
// Shared constants and types for the 640x480 8-bit image memory arbiter.
// Five banks: four of BANK_DEPTH bytes and a shorter last bank.
package img_mem_pkg;

  localparam int ADDR_W          = 19;
  localparam int BANK_DEPTH      = 65000;
  localparam int NUM_BANKS       = 5;
  localparam int IMG_PIXELS      = 307200;
  localparam int LAST_BANK_DEPTH = IMG_PIXELS - (NUM_BANKS - 1) * BANK_DEPTH;
  localparam logic [2:0] MAX_STARVE = 3'd4;

  typedef logic [ADDR_W-1:0] pix_addr_t;

  typedef enum logic [1:0] {S_IDLE, S_VGA, S_CPU} arb_state_t;

  function automatic pix_addr_t bank_base(input logic [2:0] bank);
    return pix_addr_t'(int'(bank) * BANK_DEPTH);
  endfunction

endpackage

// File: rtl/img_bank_decode.sv
// Combinational flat pixel address -> bank select, bank offset and range flag.
import img_mem_pkg::*;

module img_bank_decode (
  input  logic [18:0] addr_i,
  output logic [2:0]  bank_o,
  output logic [15:0] offset_o,
  output logic        oor_o
);

  pix_addr_t offset_full;

  // Bank index is the number of bank boundaries at or below the address.
  always_comb begin
    bank_o = '0;
    for (int b = 1; b < NUM_BANKS; b++) begin
      if (addr_i >= bank_base(3'(b))) bank_o = bank_o + 3'd1;
    end
    offset_full = addr_i - bank_base(bank_o);
    offset_o    = offset_full[15:0];
    oor_o       = (bank_o == 3'(NUM_BANKS - 1)) &&
                  (offset_full >= pix_addr_t'(LAST_BANK_DEPTH));
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Image memory arbiter: VGA fetch has priority, CPU is forced through after MAX_STARVE losses.
// Define IMG_ARB_STATS_EN to add saturating grant/stall statistics counters.
import img_mem_pkg::*;

module img_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [18:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [7:0]  vga_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_bank,
  output logic [15:0] mem_offset,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
`ifdef IMG_ARB_STATS_EN
  ,
  output logic [31:0] stat_vga_gnt,
  output logic [31:0] stat_cpu_gnt,
  output logic [31:0] stat_cpu_stall
`endif
);

  arb_state_t  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        vga_rvalid_q, cpu_rvalid_q, cpu_err_q, oor_q;
  logic [7:0]  vga_rdata_q, cpu_rdata_q;
  logic [7:0]  ret_data, cpu_byte;
  logic [18:0] dec_addr;
  logic [2:0]  dec_bank;
  logic [15:0] dec_offset;
  logic        dec_oor, any_gnt;

  always_comb begin
    vga_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    state_d  = S_IDLE;
    starve_d = starve_q;
    if (!rst) begin
      if (vga_req && !(cpu_req && starve_q == MAX_STARVE)) vga_gnt = 1'b1;
      else if (cpu_req)                                     cpu_gnt = 1'b1;
    end
    if (vga_gnt)      state_d = S_VGA;
    else if (cpu_gnt) state_d = S_CPU;
    if (!cpu_req || cpu_gnt)                      starve_d = '0;
    else if (vga_gnt && starve_q != MAX_STARVE)   starve_d = starve_q + 3'd1;
  end

  // One decoder serves whichever requester won this cycle.
  assign dec_addr = cpu_gnt ? cpu_addr : vga_addr;

  img_bank_decode u_decode (
    .addr_i   (dec_addr),
    .bank_o   (dec_bank),
    .offset_o (dec_offset),
    .oor_o    (dec_oor)
  );

  assign any_gnt    = vga_gnt | cpu_gnt;
  assign mem_en     = any_gnt && !dec_oor;
  assign mem_we     = cpu_gnt && cpu_we && !dec_oor;
  assign mem_bank   = any_gnt ? dec_bank : 3'd0;
  assign mem_offset = any_gnt ? dec_offset : 16'd0;
  assign mem_wdata  = cpu_gnt ? cpu_wdata : 8'd0;

  // Out-of-range accesses never touched memory, so they return zero.
  assign ret_data   = oor_q ? 8'h00 : mem_rdata;
  assign vga_rdata  = (state_q == S_VGA) ? ret_data : vga_rdata_q;
  assign cpu_byte   = cpu_rvalid_q ? ret_data : cpu_rdata_q;
  assign cpu_rdata  = {24'h0, cpu_byte};
  assign vga_rvalid = vga_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      vga_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      oor_q        <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      vga_rvalid_q <= vga_gnt;
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      cpu_err_q    <= cpu_gnt && dec_oor;
      oor_q        <= dec_oor;
      vga_rdata_q  <= vga_rdata;
      cpu_rdata_q  <= cpu_byte;
    end
  end

`ifdef IMG_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_vga_gnt   <= '0;
      stat_cpu_gnt   <= '0;
      stat_cpu_stall <= '0;
    end else begin
      if (vga_gnt && stat_vga_gnt != '1)               stat_vga_gnt   <= stat_vga_gnt + 32'd1;
      if (cpu_gnt && stat_cpu_gnt != '1)               stat_cpu_gnt   <= stat_cpu_gnt + 32'd1;
      if (cpu_req && !cpu_gnt && stat_cpu_stall != '1) stat_cpu_stall <= stat_cpu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed testbench for img_mem_arbiter: vector table plus reset and starvation sequences.
// Stats checks are compiled in when IMG_ARB_STATS_EN is defined.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req, cpu_req, cpu_we;
  logic [18:0] vga_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, cpu_err;
  logic [7:0]  vga_rdata;
  logic [31:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_bank;
  logic [15:0] mem_offset;
  logic [7:0]  mem_wdata, mem_rdata;
`ifdef IMG_ARB_STATS_EN
  logic [31:0] stat_vga_gnt, stat_cpu_gnt, stat_cpu_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  img_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_bank   (mem_bank),
    .mem_offset (mem_offset),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef IMG_ARB_STATS_EN
    ,
    .stat_vga_gnt   (stat_vga_gnt),
    .stat_cpu_gnt   (stat_cpu_gnt),
    .stat_cpu_stall (stat_cpu_stall)
`endif
  );

  // Memory model: unwritten locations read back offset low byte XOR bank number.
  logic [7:0] wmem [int];
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    int idx;
    idx = int'({mem_bank, mem_offset});
    if (mem_en) begin
      if (mem_we) wmem[idx] = mem_wdata;
      else if (wmem.exists(idx)) mem_rdata <= wmem[idx];
      else mem_rdata <= mem_offset[7:0] ^ {5'b0, mem_bank};
    end
  end

  typedef struct {
    logic        vReq;
    logic [18:0] vAddr;
    logic        cReq;
    logic        cWe;
    logic [18:0] cAddr;
    logic [7:0]  cWdata;
    logic        eVGnt;
    logic        eCGnt;
    logic        eEn;
    logic        eWe;
    logic [2:0]  eBank;
    logic [15:0] eOff;
    logic        eVValid;
    logic        eCValid;
    logic        eErr;
    logic [7:0]  eData;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  // One access cycle, comb checks mid-cycle, then registered checks in the return cycle.
  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    vga_req   = v.vReq;
    vga_addr  = v.vAddr;
    cpu_req   = v.cReq;
    cpu_we    = v.cWe;
    cpu_addr  = v.cAddr;
    cpu_wdata = v.cWdata;
    #1;
    checkOutput($sformatf("v%0d vga_gnt", n), 32'(vga_gnt), 32'(v.eVGnt));
    checkOutput($sformatf("v%0d cpu_gnt", n), 32'(cpu_gnt), 32'(v.eCGnt));
    checkOutput($sformatf("v%0d mem_en", n), 32'(mem_en), 32'(v.eEn));
    checkOutput($sformatf("v%0d mem_we", n), 32'(mem_we), 32'(v.eWe));
    if (v.eEn) begin
      checkOutput($sformatf("v%0d mem_bank", n), 32'(mem_bank), 32'(v.eBank));
      checkOutput($sformatf("v%0d mem_offset", n), 32'(mem_offset), 32'(v.eOff));
    end
    if (v.eWe) checkOutput($sformatf("v%0d mem_wdata", n), 32'(mem_wdata), 32'(v.cWdata));
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput($sformatf("v%0d vga_rvalid", n), 32'(vga_rvalid), 32'(v.eVValid));
    checkOutput($sformatf("v%0d cpu_rvalid", n), 32'(cpu_rvalid), 32'(v.eCValid));
    checkOutput($sformatf("v%0d cpu_err", n), 32'(cpu_err), 32'(v.eErr));
    if (v.eVValid) checkOutput($sformatf("v%0d vga_rdata", n), 32'(vga_rdata), 32'(v.eData));
    if (v.eCValid) checkOutput($sformatf("v%0d cpu_rdata", n), cpu_rdata, {24'h0, v.eData});
  endtask

  initial begin
    logic [9:0] expVgaPat;
    expVgaPat = 10'b0111101111;

    //          vReq vAddr      cReq cWe cAddr      wdata  VGnt CGnt En We Bank Off        VVal CVal Err Data
    vecs[0]  = '{1'b1, 19'd0,      1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0,     1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 19'd64999,  1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd64999, 1'b1, 1'b0, 1'b0, 8'hE7};
    vecs[2]  = '{1'b1, 19'd65000,  1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 16'd0,     1'b1, 1'b0, 1'b0, 8'h01};
    vecs[3]  = '{1'b1, 19'd307199, 1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 16'd47199, 1'b1, 1'b0, 1'b0, 8'h5B};
    vecs[4]  = '{1'b0, 19'd0,      1'b1, 1'b1, 19'd130001, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'd1,     1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 19'd0,      1'b1, 1'b0, 19'd130001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'd1,     1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 19'd0,      1'b1, 1'b0, 19'd307200, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0,     1'b0, 1'b1, 1'b1, 8'h00};
    vecs[7]  = '{1'b1, 19'd307200, 1'b0, 1'b0, 19'd0,      8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0,     1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 19'd0,      1'b1, 1'b0, 19'd65003,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'd3,     1'b0, 1'b1, 1'b0, 8'h02};
    vecs[9]  = '{1'b0, 19'd0,      1'b1, 1'b1, 19'd400000, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0,     1'b0, 1'b0, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 19'd0,      1'b1, 1'b0, 19'd195258, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'd258,   1'b0, 1'b1, 1'b0, 8'h01};

    // Reset state, with requests present to confirm grants are suppressed.
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vga_req = 1'b1;
    cpu_req = 1'b1;
    #1;
    checkOutput("rst vga_gnt", 32'(vga_gnt), 32'd0);
    checkOutput("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("rst mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst cpu_err", 32'(cpu_err), 32'd0);
    checkOutput("rst vga_rdata", 32'(vga_rdata), 32'd0);
    checkOutput("rst cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    idleInputs();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Reset lands in the cycle after a VGA grant: its return must be dropped.
    @(negedge clk);
    vga_req  = 1'b1;
    vga_addr = 19'd65000;
    #1;
    checkOutput("midrst vga_gnt", 32'(vga_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b1;
    #1;
    checkOutput("midrst vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("midrst vga_rdata", 32'(vga_rdata), 32'd0);
    checkOutput("midrst cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("midrst vga_gnt forced", 32'(vga_gnt), 32'd0);
    checkOutput("midrst cpu_gnt forced", 32'(cpu_gnt), 32'd0);
    checkOutput("midrst mem_en forced", 32'(mem_en), 32'd0);
    @(negedge clk);
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("postrst vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("postrst cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // Both requesters held for 10 cycles: VGA x4, CPU x1, repeated.
    @(negedge clk);
    vga_req  = 1'b1;
    vga_addr = 19'd10;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 19'd20;
    for (int k = 0; k < 10; k++) begin
      #1;
      checkOutput($sformatf("starve c%0d vga_gnt", k), 32'(vga_gnt), 32'(expVgaPat[k]));
      checkOutput($sformatf("starve c%0d cpu_gnt", k), 32'(cpu_gnt), 32'(!expVgaPat[k]));
      if (k > 0) begin
        checkOutput($sformatf("starve c%0d vga_rvalid", k), 32'(vga_rvalid), 32'(expVgaPat[k-1]));
        checkOutput($sformatf("starve c%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(!expVgaPat[k-1]));
      end
      if (k == 1) checkOutput("starve first vga_rdata", 32'(vga_rdata), 32'h0A);
      if (k == 5) checkOutput("starve first cpu_rdata", cpu_rdata, 32'h14);
      @(negedge clk);
    end
    idleInputs();
    #1;
`ifdef IMG_ARB_STATS_EN
    checkOutput("stat_vga_gnt", stat_vga_gnt, 32'd8);
    checkOutput("stat_cpu_gnt", stat_cpu_gnt, 32'd2);
    checkOutput("stat_cpu_stall", stat_cpu_stall, 32'd8);
`endif
    checkOutput("starve last cpu_rvalid", 32'(cpu_rvalid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
